// File: rtl/block_aligner.sv
// Buffers a group of floating-point operands while tracking the largest exponent,
// then replays each one as a two's-complement fixed-point value aligned to that exponent.
module block_aligner #(
    parameter int DEPTH  = 16,
    parameter int MANT_W = 11,
    parameter int EXP_W  = 6,
    parameter int SUM_W  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [EXP_W-1:0] out_exp_max,
    output logic             out_last
);
    // state   | meaning
    // COLLECT | accepting operands, tracking the running maximum exponent
    // DRAIN   | replaying buffered operands aligned to the latched maximum
    typedef enum logic {COLLECT, DRAIN} state_t;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t state, state_next;

    logic              buf_sign [DEPTH];
    logic [MANT_W-1:0] buf_mant [DEPTH];
    logic [EXP_W-1:0]  buf_exp  [DEPTH];

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] idx;
    logic [EXP_W-1:0] run_max;
    logic [EXP_W-1:0] max_upd;
    logic             accept;
    logic             close;
    logic             drain_done;
    logic             e0_sign;
    logic [MANT_W-1:0] e0_mant;
    logic [EXP_W-1:0] e0_exp;

    function automatic logic [SUM_W-1:0] align(input logic s, input logic [MANT_W-1:0] m,
                                               input logic [EXP_W-1:0] e,
                                               input logic [EXP_W-1:0] emax);
        logic [EXP_W-1:0] sh;
        logic [SUM_W-2:0] full;
        logic [SUM_W-2:0] mag;
        sh   = emax - e;
        full = {m, {(SUM_W-1-MANT_W){1'b0}}};
        mag  = (sh >= EXP_W'(SUM_W-1)) ? '0 : (full >> sh);
        return s ? (SUM_W'(0) - {1'b0, mag}) : {1'b0, mag};
    endfunction

    assign in_ready   = (state == COLLECT);
    assign accept     = in_valid && in_ready;
    assign close      = accept && (in_last || (count == CNT_W'(DEPTH - 1)));
    assign drain_done = (state == DRAIN) && out_valid && out_ready && out_last;
    assign max_upd    = ((in_mant != '0) && (in_exp > run_max)) ? in_exp : run_max;

    // A group of one closes on its own operand before it reaches the buffer.
    assign e0_sign = (count == '0) ? in_sign : buf_sign[0];
    assign e0_mant = (count == '0) ? in_mant : buf_mant[0];
    assign e0_exp  = (count == '0) ? in_exp  : buf_exp[0];

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (close)      state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = COLLECT;
            default:                 state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_sign[count[IDX_W-1:0]] <= in_sign;
            buf_mant[count[IDX_W-1:0]] <= in_mant;
            buf_exp[count[IDX_W-1:0]]  <= in_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            idx         <= '0;
            run_max     <= '0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_exp_max <= '0;
            out_last    <= 1'b0;
        end else if (state == COLLECT) begin
            if (accept) begin
                count   <= count + CNT_W'(1);
                run_max <= max_upd;
            end
            // Entry 0 is loaded on the closing edge so output starts the next cycle.
            if (close) begin
                out_valid   <= 1'b1;
                out_sum     <= align(e0_sign, e0_mant, e0_exp, max_upd);
                out_exp_max <= max_upd;
                out_last    <= (count == '0);
                idx         <= CNT_W'(1);
            end
        end else begin
            if (drain_done) begin
                out_valid <= 1'b0;
                count     <= '0;
                run_max   <= '0;
                idx       <= '0;
            end else if ((!out_valid || out_ready) && (idx < count)) begin
                out_valid <= 1'b1;
                out_sum   <= align(buf_sign[idx[IDX_W-1:0]], buf_mant[idx[IDX_W-1:0]],
                                   buf_exp[idx[IDX_W-1:0]], out_exp_max);
                out_last  <= (idx == count - CNT_W'(1));
                idx       <= idx + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_block_aligner.sv
// Directed bench for block_aligner: hand-computed aligned values, backpressure,
// depth overflow and mid-drain reset.
module tb_block_aligner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [10:0] in_mant = '0;
    logic [5:0]  in_exp = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_sum;
    logic [5:0]  out_exp_max;
    logic        out_last;

    int n_checks = 0;
    int n_fails  = 0;

    block_aligner dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_mant(in_mant), .in_exp(in_exp), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_exp_max(out_exp_max), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic send(input logic s, input logic [10:0] m, input logic [5:0] e, input logic l);
        int n = 0;
        in_valid = 1'b1; in_sign = s; in_mant = m; in_exp = e; in_last = l;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin
            n_checks++; n_fails++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic recv(output logic [19:0] s, output logic [5:0] e, output logic l, output logic ir);
        int n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        if (!out_valid) begin
            n_checks++; n_fails++;
            $display("FAIL recv_timeout: out_valid=%0b required 1", out_valid);
        end
        s = out_sum; e = out_exp_max; l = out_last; ir = in_ready;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_checks++; if (out_sum !== 20'h0) begin n_fails++; $display("FAIL reset_out_sum: got %h want 00000", out_sum); end
        n_checks++; if (out_exp_max !== 6'd0) begin n_fails++; $display("FAIL reset_exp_max: got %0d want 0", out_exp_max); end
        n_checks++; if (out_last !== 1'b0) begin n_fails++; $display("FAIL reset_out_last: got %0b want 0", out_last); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [19:0] s; logic [5:0] e; logic l, ir;
        out_ready = 1'b1;
        send(1'b0, 11'h400, 6'd10, 1'b0);
        send(1'b1, 11'h400, 6'd12, 1'b1);
        recv(s, e, l, ir);
        n_checks++; if (s !== 20'h10000) begin n_fails++; $display("FAIL basic_sum0: got %h want 10000", s); end
        n_checks++; if (e !== 6'd12) begin n_fails++; $display("FAIL basic_exp0: got %0d want 12", e); end
        n_checks++; if (l !== 1'b0) begin n_fails++; $display("FAIL basic_last0: got %0b want 0", l); end
        n_checks++; if (ir !== 1'b0) begin n_fails++; $display("FAIL basic_ready0: got %0b want 0", ir); end
        recv(s, e, l, ir);
        n_checks++; if (s !== 20'hC0000) begin n_fails++; $display("FAIL basic_sum1: got %h want C0000", s); end
        n_checks++; if (l !== 1'b1) begin n_fails++; $display("FAIL basic_last1: got %0b want 1", l); end
        n_checks++; if (ir !== 1'b0) begin n_fails++; $display("FAIL basic_ready1: got %0b want 0", ir); end
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL basic_ready_after: got %0b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL basic_valid_after: got %0b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_large_shift();
        logic [19:0] s; logic [5:0] e; logic l, ir;
        send(1'b0, 11'h7FF, 6'd0, 1'b0);
        send(1'b1, 11'h7FF, 6'd30, 1'b1);
        recv(s, e, l, ir);
        n_checks++; if (s !== 20'h00000) begin n_fails++; $display("FAIL shift_sum0: got %h want 00000", s); end
        n_checks++; if (e !== 6'd30) begin n_fails++; $display("FAIL shift_exp: got %0d want 30", e); end
        recv(s, e, l, ir);
        n_checks++; if (s !== 20'h80100) begin n_fails++; $display("FAIL shift_sum1: got %h want 80100", s); end
        n_checks++; if (l !== 1'b1) begin n_fails++; $display("FAIL shift_last1: got %0b want 1", l); end
    endtask

    task automatic test_zero();
        logic [19:0] s; logic [5:0] e; logic l, ir;
        send(1'b1, 11'h000, 6'd40, 1'b0);
        send(1'b0, 11'h400, 6'd5, 1'b1);
        recv(s, e, l, ir);
        n_checks++; if (e !== 6'd5) begin n_fails++; $display("FAIL zero_exp: got %0d want 5", e); end
        n_checks++; if (s !== 20'h00000) begin n_fails++; $display("FAIL zero_sum0: got %h want 00000", s); end
        recv(s, e, l, ir);
        n_checks++; if (s !== 20'h40000) begin n_fails++; $display("FAIL zero_sum1: got %h want 40000", s); end
        send(1'b1, 11'h000, 6'd7, 1'b0);
        send(1'b0, 11'h000, 6'd3, 1'b1);
        recv(s, e, l, ir);
        n_checks++; if (e !== 6'd0) begin n_fails++; $display("FAIL allzero_exp: got %0d want 0", e); end
        n_checks++; if (s !== 20'h00000) begin n_fails++; $display("FAIL allzero_sum0: got %h want 00000", s); end
        recv(s, e, l, ir);
        n_checks++; if (s !== 20'h00000) begin n_fails++; $display("FAIL allzero_sum1: got %h want 00000", s); end
        n_checks++; if (l !== 1'b1) begin n_fails++; $display("FAIL allzero_last: got %0b want 1", l); end
    endtask

    task automatic test_backpressure();
        logic [19:0] got[$];
        logic [19:0] exp_v[4];
        logic done;
        exp_v[0] = 20'h00100; exp_v[1] = 20'h00200; exp_v[2] = 20'h00300; exp_v[3] = 20'h00400;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 11'(i + 1), 6'd3, (i == 3));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== 20'h00100 || out_last !== 1'b0) begin
                n_fails++;
                $display("FAIL bp_hold c=%0d: valid=%0b sum=%h last=%0b want 1 00100 0", c, out_valid, out_sum, out_last);
            end
        end
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            out_ready = (c % 2 == 0);
            if (out_valid && out_ready) begin
                got.push_back(out_sum);
                if (out_last) done = 1'b1;
            end
        end
        n_checks++; if (got.size() != 4) begin n_fails++; $display("FAIL bp_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_v[i]) begin n_fails++; $display("FAIL bp_value%0d: got %h want %h", i, got[i], exp_v[i]); end
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL bp_valid_after: got %0b want 0", out_valid); end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic test_depth_overflow();
        logic [19:0] s; logic [5:0] e; logic l, ir;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(1'b0, 11'(i + 1), 6'd0, 1'b0);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL depth_closed: in_ready=%0b want 0", in_ready); end
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            recv(s, e, l, ir);
            n_checks++;
            if (s !== 20'((i + 1) << 8) || l !== (i == 15) || ir !== 1'b0) begin
                n_fails++;
                $display("FAIL depth_entry%0d: sum=%h last=%0b in_ready=%0b want %h %0b 0", i, s, l, ir, 20'((i + 1) << 8), (i == 15));
            end
        end
        send(1'b0, 11'd17, 6'd0, 1'b1);
        recv(s, e, l, ir);
        n_checks++; if (s !== 20'h01100 || l !== 1'b1) begin n_fails++; $display("FAIL depth_17th: sum=%h last=%0b want 01100 1", s, l); end
    endtask

    task automatic test_reset_in_drain();
        logic [19:0] s; logic [5:0] e; logic l, ir;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b0, 11'((i + 1) << 8), 6'd0, (i == 4));
        recv(s, e, l, ir);
        n_checks++; if (s !== 20'h10000) begin n_fails++; $display("FAIL rd_sum0: got %h want 10000", s); end
        recv(s, e, l, ir);
        n_checks++; if (s !== 20'h20000) begin n_fails++; $display("FAIL rd_sum1: got %h want 20000", s); end
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL rd_valid: got %0b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL rd_ready: got %0b want 1", in_ready); end
        @(posedge clk); #1;
        send(1'b1, 11'h123, 6'd9, 1'b1);
        recv(s, e, l, ir);
        n_checks++; if (s !== 20'hEDD00 || e !== 6'd9 || l !== 1'b1) begin
            n_fails++; $display("FAIL rd_single: sum=%h exp=%0d last=%0b want EDD00 9 1", s, e, l);
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL rd_no_stale: out_valid=%0b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_large_shift();
        test_zero();
        test_backpressure();
        test_depth_overflow();
        test_reset_in_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
